// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ==========================================================================
// ex_muldiv_if : ID/EX -> EX -> MEM handshake and result bundle   rev 1.0
// ==========================================================================
interface ex_muldiv_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              valid_i;
  logic [4:0]        op_i;
  logic [XLEN-1:0]   reg1_i;
  logic [XLEN-1:0]   reg2_i;
  logic [REG_AW-1:0] wd_i;
  logic              wreg_i;
  logic              flush_i;
  logic              valid_o;
  logic [REG_AW-1:0] wd_o;
  logic              wreg_o;
  logic [XLEN-1:0]   wdata_o;
  logic              ov_o;
  logic [XLEN-1:0]   hi_o;
  logic [XLEN-1:0]   lo_o;
  logic              stallreq;

  modport master (
    output valid_i, op_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    input  valid_o, wd_o, wreg_o, wdata_o, ov_o, hi_o, lo_o, stallreq
  );

  modport slave (
    input  valid_i, op_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    output valid_o, wd_o, wreg_o, wdata_o, ov_o, hi_o, lo_o, stallreq
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ==========================================================================
// ex_muldiv : execute stage, ALU + mul / iterative div + HI/LO      rev 1.0
// ==========================================================================
module ex_muldiv #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  wire logic  clk,
  input  wire logic  rst,
  ex_muldiv_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);
  localparam logic [CW-1:0] c_CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

  localparam logic [4:0] c_OP_ADD  = 5'd1,  c_OP_ADDU = 5'd2,  c_OP_SUB  = 5'd3;
  localparam logic [4:0] c_OP_SLT  = 5'd4,  c_OP_SLTU = 5'd5,  c_OP_AND  = 5'd6;
  localparam logic [4:0] c_OP_OR   = 5'd7,  c_OP_XOR  = 5'd8,  c_OP_NOR  = 5'd9;
  localparam logic [4:0] c_OP_SLL  = 5'd10, c_OP_SRL  = 5'd11, c_OP_SRA  = 5'd12;
  localparam logic [4:0] c_OP_MULT = 5'd13, c_OP_MULTU = 5'd14, c_OP_DIV = 5'd15;
  localparam logic [4:0] c_OP_DIVU = 5'd16, c_OP_MFHI = 5'd17, c_OP_MFLO = 5'd18;
  localparam logic [4:0] c_OP_MTHI = 5'd19, c_OP_MTLO = 5'd20;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIN = 2'd3} state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_acc;     // remainder during divide, product high after multiply
  logic [XLEN-1:0]   r_quo;     // dividend/quotient shifter, multiplicand, product low
  logic [XLEN-1:0]   r_dvs;
  logic              r_sgn, r_neg_q, r_neg_r;
  logic [CW-1:0]     r_cnt;
  logic [REG_AW-1:0] r_md_wd;
  logic              r_valid, r_wreg, r_ov;
  logic [REG_AW-1:0] r_wd;
  logic [XLEN-1:0]   r_wdata, r_hi, r_lo;

  logic [XLEN-1:0]   w_a, w_b, w_sum, w_result, w_a_mag, w_b_mag, w_fin_hi, w_fin_lo;
  logic [XLEN:0]     w_sub, w_shift, w_diff;
  logic [2*XLEN-1:0] w_ext_a, w_ext_b, w_prod;
  logic [SHW-1:0]    w_shamt;
  logic              w_add_ov, w_sub_ov, w_slt, w_sltu, w_ov, w_is_md, w_is_wr;
  logic              w_a_neg, w_b_neg, w_b_zero;

  assign w_a      = bus.reg1_i;
  assign w_b      = bus.reg2_i;
  assign w_shamt  = w_b[SHW-1:0];
  assign w_sum    = w_a + w_b;
  assign w_sub    = {1'b0, w_a} + {1'b0, ~w_b} + {{XLEN{1'b0}}, 1'b1};
  assign w_add_ov = (w_a[XLEN-1] == w_b[XLEN-1]) && (w_sum[XLEN-1] != w_a[XLEN-1]);
  assign w_sub_ov = (w_a[XLEN-1] != w_b[XLEN-1]) && (w_sub[XLEN-1] != w_a[XLEN-1]);
  assign w_slt    = (w_a[XLEN-1] != w_b[XLEN-1]) ? w_a[XLEN-1] : w_sub[XLEN-1];
  assign w_sltu   = ~w_sub[XLEN];
  assign w_ov     = ((bus.op_i == c_OP_ADD) && w_add_ov) || ((bus.op_i == c_OP_SUB) && w_sub_ov);
  assign w_is_md  = (bus.op_i >= c_OP_MULT) && (bus.op_i <= c_OP_DIVU);
  assign w_is_wr  = bus.wreg_i && !w_ov &&
                    (((bus.op_i >= c_OP_ADD) && (bus.op_i <= c_OP_SRA)) ||
                     (bus.op_i == c_OP_MFHI) || (bus.op_i == c_OP_MFLO));

  // Signed divide works on magnitudes; signs are reapplied in FIN.
  assign w_a_neg  = (bus.op_i == c_OP_DIV) && w_a[XLEN-1];
  assign w_b_neg  = (bus.op_i == c_OP_DIV) && w_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -w_a : w_a;
  assign w_b_mag  = w_b_neg ? -w_b : w_b;
  assign w_b_zero = (w_b == '0);

  assign w_shift  = {r_acc, r_quo[XLEN-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_ext_a  = {{XLEN{r_sgn & r_quo[XLEN-1]}}, r_quo};
  assign w_ext_b  = {{XLEN{r_sgn & r_dvs[XLEN-1]}}, r_dvs};
  assign w_prod   = w_ext_a * w_ext_b;
  assign w_fin_lo = r_neg_q ? -r_quo : r_quo;
  assign w_fin_hi = r_neg_r ? -r_acc : r_acc;

  always_comb begin
    w_result = '0;
    case (bus.op_i)
      c_OP_ADD, c_OP_ADDU: w_result = w_sum;
      c_OP_SUB:  w_result = w_sub[XLEN-1:0];
      c_OP_SLT:  w_result = {{(XLEN-1){1'b0}}, w_slt};
      c_OP_SLTU: w_result = {{(XLEN-1){1'b0}}, w_sltu};
      c_OP_AND:  w_result = w_a & w_b;
      c_OP_OR:   w_result = w_a | w_b;
      c_OP_XOR:  w_result = w_a ^ w_b;
      c_OP_NOR:  w_result = ~(w_a | w_b);
      c_OP_SLL:  w_result = w_a << w_shamt;
      c_OP_SRL:  w_result = w_a >> w_shamt;
      c_OP_SRA:  w_result = $signed(w_a) >>> w_shamt;
      c_OP_MFHI: w_result = r_hi;
      c_OP_MFLO: w_result = r_lo;
      default:   w_result = '0;
    endcase
  end

  assign bus.stallreq = rst && !bus.flush_i &&
                        ((r_state == S_MUL) || (r_state == S_DIV) ||
                         ((r_state == S_IDLE) && bus.valid_i && w_is_md));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
      r_md_wd <= '0;
      r_valid <= 1'b0;
      r_wreg  <= 1'b0;
      r_ov    <= 1'b0;
      r_wd    <= '0;
      r_wdata <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_valid <= 1'b0;
      r_wreg  <= 1'b0;
      r_ov    <= 1'b0;
      if (bus.flush_i) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.valid_i && w_is_md) begin
              r_md_wd <= bus.wd_i;
              r_sgn   <= (bus.op_i == c_OP_MULT);
              r_acc   <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              if (bus.op_i <= c_OP_MULTU) begin
                r_quo   <= w_a;
                r_dvs   <= w_b;
                r_state <= S_MUL;
              end else if (w_b_zero) begin
                r_quo   <= '1;
                r_acc   <= w_a;
                r_state <= S_FIN;
              end else begin
                r_quo   <= w_a_mag;
                r_dvs   <= w_b_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_cnt   <= c_CNT_INIT;
                r_state <= S_DIV;
              end
            end else if (bus.valid_i) begin
              r_valid <= 1'b1;
              r_wd    <= bus.wd_i;
              r_wdata <= w_result;
              r_wreg  <= w_is_wr;
              r_ov    <= w_ov;
              if (bus.op_i == c_OP_MTHI) r_hi <= w_a;
              if (bus.op_i == c_OP_MTLO) r_lo <= w_a;
            end
          end
          S_MUL: begin
            {r_acc, r_quo} <= w_prod;
            r_state        <= S_FIN;
          end
          S_DIV: begin
            if (!w_diff[XLEN]) begin
              r_acc <= w_diff[XLEN-1:0];
              r_quo <= {r_quo[XLEN-2:0], 1'b1};
            end else begin
              r_acc <= w_shift[XLEN-1:0];
              r_quo <= {r_quo[XLEN-2:0], 1'b0};
            end
            r_cnt <= r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) r_state <= S_FIN;
          end
          default: begin
            r_hi    <= w_fin_hi;
            r_lo    <= w_fin_lo;
            r_valid <= 1'b1;
            r_wd    <= r_md_wd;
            r_wdata <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.valid_o = r_valid;
  assign bus.wd_o    = r_wd;
  assign bus.wreg_o  = r_wreg;
  assign bus.wdata_o = r_wdata;
  assign bus.ov_o    = r_ov;
  assign bus.hi_o    = r_hi;
  assign bus.lo_o    = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ==========================================================================
// tb_ex_muldiv : directed vector bench for ex_muldiv (XLEN 32 and 16) rev 1.0
// ==========================================================================
`timescale 1ns/1ps
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32), .REG_AW(5)) bus ();
  ex_muldiv_if #(.XLEN(16), .REG_AW(5)) bus16 ();

  ex_muldiv #(.XLEN(32), .REG_AW(5)) dut   (.clk(clk), .rst(rst), .bus(bus));
  ex_muldiv #(.XLEN(16), .REG_AW(5)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct {
    string       nm;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ed;
    logic        ew;
    logic        eov;
  } vec_t;

  vec_t vt[16];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.valid_i = v;
    bus.op_i    = op;
    bus.reg1_i  = a;
    bus.reg2_i  = b;
    bus.wd_i    = 5'd3;
    bus.wreg_i  = 1'b1;
    #1;
  endtask

  // Issues a mul/div, holds it while stalled, then checks stall length, retire pulse and HI/LO.
  task automatic run_md(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int estall, input bit mf_after);
    int stalls = 0;
    int pulses = 0;
    int guard  = 0;
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    step();
    drive(1'b1, op, a, b);
    while (bus.stallreq && guard < 100) begin
      stalls++;
      if (bus.valid_o) pulses++;
      step();
      guard++;
    end
    chk({nm, " bounded"}, 64'(guard < 100), 64'd1);
    chk({nm, " stall cycles"}, 64'(stalls), 64'(estall));
    if (bus.valid_o) pulses++;
    chk({nm, " early valid"}, 64'(pulses), 64'd0);
    step();
    if (mf_after) drive(1'b1, 5'd17, 32'h0, 32'h0);
    else          drive(1'b0, 5'd0, 32'h0, 32'h0);
    chk({nm, " valid"}, bus.valid_o, 1);
    chk({nm, " wreg"},  bus.wreg_o, 0);
    chk({nm, " wdata"}, bus.wdata_o, 0);
    chk({nm, " hi"},    bus.hi_o, ehi);
    chk({nm, " lo"},    bus.lo_o, elo);
    step();
    if (mf_after) begin
      chk({nm, " mfhi valid"}, bus.valid_o, 1);
      chk({nm, " mfhi data"},  bus.wdata_o, ehi);
      drive(1'b0, 5'd0, 32'h0, 32'h0);
    end else begin
      chk({nm, " single pulse"}, bus.valid_o, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st16;
    int g16;
    vt[0]  = '{"ADD ovf",      5'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vt[1]  = '{"ADDU",         5'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0};
    vt[2]  = '{"SUB neg",      5'd3,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0};
    vt[3]  = '{"SUB ovf",      5'd3,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vt[4]  = '{"ADD wrap",     5'd1,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vt[5]  = '{"SLT",          5'd4,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0};
    vt[6]  = '{"SLTU",         5'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vt[7]  = '{"SLT extreme",  5'd4,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
    vt[8]  = '{"AND",          5'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1, 1'b0};
    vt[9]  = '{"OR",           5'd7,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b1, 1'b0};
    vt[10] = '{"XOR",          5'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 1'b0};
    vt[11] = '{"NOR",          5'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b1, 1'b0};
    vt[12] = '{"SLL masked",   5'd10, 32'h00000001, 32'h00000023, 32'h00000008, 1'b1, 1'b0};
    vt[13] = '{"SRL",          5'd11, 32'h80000000, 32'h00000004, 32'h08000000, 1'b1, 1'b0};
    vt[14] = '{"SRA",          5'd12, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b1, 1'b0};
    vt[15] = '{"SRA 31",       5'd12, 32'h40000000, 32'h0000001F, 32'h00000000, 1'b1, 1'b0};

    rst = 1'b0;
    bus.flush_i = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    bus16.valid_i = 1'b0; bus16.op_i = 5'd0; bus16.reg1_i = '0; bus16.reg2_i = '0;
    bus16.wd_i = 5'd0; bus16.wreg_i = 1'b0; bus16.flush_i = 1'b0;
    step(); step();
    chk("reset valid", bus.valid_o, 0);
    chk("reset wdata", bus.wdata_o, 0);
    chk("reset hi",    bus.hi_o, 0);
    chk("reset lo",    bus.lo_o, 0);
    drive(1'b1, 5'd15, 32'h9, 32'h2);
    chk("reset stallreq", bus.stallreq, 0);
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    rst = 1'b1;
    step();

    // Back-to-back single-cycle ops at full throughput.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vt[i].op, vt[i].a, vt[i].b);
      step();
      chk({vt[i].nm, " valid"}, bus.valid_o, 1);
      chk({vt[i].nm, " data"},  bus.wdata_o, vt[i].ed);
      chk({vt[i].nm, " wreg"},  bus.wreg_o, vt[i].ew);
      chk({vt[i].nm, " ov"},    bus.ov_o, vt[i].eov);
    end
    chk("wd passthrough", bus.wd_o, 3);
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    step();
    chk("idle no retire", bus.valid_o, 0);

    drive(1'b1, 5'd20, 32'h1234, 32'h0);
    step();
    chk("MTLO wreg", bus.wreg_o, 0);
    drive(1'b1, 5'd18, 32'h0, 32'h0);
    step();
    chk("MFLO data", bus.wdata_o, 32'h1234);
    drive(1'b1, 5'd19, 32'hABCD, 32'h0);
    step();
    drive(1'b1, 5'd17, 32'h0, 32'h0);
    step();
    chk("MFHI data", bus.wdata_o, 32'hABCD);

    run_md("MULT",      5'd13, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 2, 1'b0);
    run_md("MULTU",     5'd14, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, 2, 1'b0);
    run_md("DIV -7/2",  5'd15, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b1);
    run_md("DIVU 7/0",  5'd16, 32'h7, 32'h0, 32'h00000007, 32'hFFFFFFFF, 1, 1'b0);
    run_md("DIV mn/-1", 5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 1'b0);
    run_md("DIVU 100/7", 5'd16, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);

    // Flush in DIV cycle 5: nothing retires and HI/LO keep the 100/7 results.
    drive(1'b1, 5'd16, 32'd50, 32'd3);
    chk("flush accept stall", bus.stallreq, 1);
    step();
    repeat (4) step();
    bus.flush_i = 1'b1;
    #1;
    chk("flush stallreq", bus.stallreq, 0);
    step();
    bus.flush_i = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    chk("flush no valid", bus.valid_o, 0);
    chk("flush idle stall", bus.stallreq, 0);
    chk("flush hi kept", bus.hi_o, 32'd2);
    chk("flush lo kept", bus.lo_o, 32'd14);
    drive(1'b1, 5'd1, 32'd2, 32'd3);
    step();
    chk("post-flush ADD valid", bus.valid_o, 1);
    chk("post-flush ADD data",  bus.wdata_o, 32'd5);

    // XLEN=16 instance.
    bus16.valid_i = 1'b1; bus16.op_i = 5'd16; bus16.reg1_i = 16'd100; bus16.reg2_i = 16'd7;
    bus16.wd_i = 5'd1; bus16.wreg_i = 1'b1;
    #1;
    st16 = 0; g16 = 0;
    while (bus16.stallreq && g16 < 100) begin
      st16++;
      step();
      g16++;
    end
    chk("x16 stall cycles", 64'(st16), 64'd17);
    step();
    bus16.valid_i = 1'b0;
    #1;
    chk("x16 valid", bus16.valid_o, 1);
    chk("x16 lo", bus16.lo_o, 16'd14);
    chk("x16 hi", bus16.hi_o, 16'd2);

    // Reset asserted in DIV cycle 10 clears everything immediately.
    drive(1'b1, 5'd19, 32'hAAAA, 32'h0);
    step();
    drive(1'b1, 5'd15, 32'd1000, 32'd3);
    step();
    repeat (9) step();
    chk("pre-reset stall", bus.stallreq, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid reset stallreq", bus.stallreq, 0);
    chk("mid reset valid",    bus.valid_o, 0);
    chk("mid reset wd",       bus.wd_o, 0);
    chk("mid reset wdata",    bus.wdata_o, 0);
    chk("mid reset hi",       bus.hi_o, 0);
    chk("mid reset lo",       bus.lo_o, 0);
    step();
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    step();
    chk("post reset stall", bus.stallreq, 0);
    chk("post reset valid", bus.valid_o, 0);
    chk("post reset hi",    bus.hi_o, 0);
    drive(1'b1, 5'd1, 32'd1, 32'd1);
    step();
    chk("post reset ADD", bus.wdata_o, 32'd2);
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised execute stage for the pipelined CPU core. It covers the existing logic, shift and arithmetic ops and adds signed/unsigned multiply, iterative divide, and HI/LO special registers. Results are registered, and a stall request holds the upstream pipeline while multi-cycle ops run. It sits between the ID/EX pipeline register and the MEM stage and drives `stallreq` to the pipeline controller.

## Interface
Parameters:
- `XLEN`, 32, datapath width; power of two, ≥ 8; `SHW` = log2(`XLEN`).
- `REG_AW`, 5, register-file address width.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  op_i/operands carry an instruction this cycle.
- `op_i`  in  5  operation code:
  - 0 NOP, 1 ADD, 2 ADDU, 3 SUB, 4 SLT, 5 SLTU
  - 6 AND, 7 OR, 8 XOR, 9 NOR
  - 10 SLL, 11 SRL, 12 SRA
  - 13 MULT, 14 MULTU, 15 DIV, 16 DIVU
  - 17 MFHI, 18 MFLO, 19 MTHI, 20 MTLO
  - 21–31 treated as NOP.
- `reg1_i`, `reg2_i`  in  XLEN  source operands.
- `wd_i`  in  REG_AW  destination register.
- `wreg_i`  in  1  destination write enable.
- `flush_i`  in  1  abort any in-flight op; drop the current input.
- `valid_o`  out  1  registered result valid, one-cycle pulse per retired instruction.
- `wd_o`  out  REG_AW  registered destination.
- `wreg_o`  out  1  registered write enable.
- `wdata_o`  out  XLEN  registered result.
- `ov_o`  out  1  ADD/SUB signed overflow flag for the instruction in `valid_o`.
- `hi_o`, `lo_o`  out  XLEN  HI/LO register contents.
- `stallreq`  out  1  combinational; upstream holds inputs stable while high.

## Operation
- Single-cycle ops (1–12, 17–20, NOP) are accepted in IDLE when `valid_i` is high. The result is registered and `valid_o`=1 the next cycle.
- Arithmetic:
  - SUB/SLT use `reg1_i` + ~`reg2_i` + 1.
  - SLT is a signed compare and SLTU an unsigned compare; the result is zero-extended 0/1.
  - ADD and SUB with signed overflow set `wreg_o`=0 and `ov_o`=1. ADDU never flags.
- Shifts shift `reg1_i` by `reg2_i[SHW-1:0]`. SRA sign-fills.
- MFHI/MFLO return `hi_o`/`lo_o`.
- MTHI/MTLO write `reg1_i` into HI/LO at the end of the accept cycle, with `wreg_o`=0.
- MULT/MULTU: the 2·XLEN product goes to {HI,LO}.
- DIV/DIVU: quotient goes to LO, remainder to HI.
  - Signed division uses magnitudes. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
  - Divide by zero: LO = all ones, HI = dividend. No iterations run.
  - Most-negative ÷ −1: LO = most-negative, HI = 0.
- Multiply/divide retire with `valid_o`=1 and `wreg_o`=0, `wdata_o`=0.
- State machine (`stallreq` shown per state):
  - IDLE (`stallreq`=0, or 1 when `valid_i` carries op 13–16): a mul/div op captures its operands and goes to MUL (13–14) or DIV (15–16). A zero divisor goes straight to FIN.
  - MUL (`stallreq`=1): registers the product, then goes to FIN.
  - DIV (`stallreq`=1): restoring radix-2 division, one quotient bit per cycle. An XLEN-cycle counter counts down; when it reaches 0 the state goes to FIN.
  - FIN (`stallreq`=0): writes HI/LO at the end of the cycle and goes to IDLE. The still-presented mul/div instruction is consumed, not restarted.
- `flush_i`: any state goes to IDLE at the next edge.
  - HI/LO are not written and `valid_o`=0 next cycle.
  - An input presented with `flush_i` is ignored.
  - `stallreq`=0 while `flush_i`=1.

## Timing
- Reset (`rst`=0, asynchronous):
  - state = IDLE.
  - `valid_o`, `wreg_o`, `ov_o` = 0.
  - `wd_o`, `wdata_o`, `hi_o`, `lo_o` = 0.
  - The divide counter is 0.
  - `stallreq`=0 while in reset.
- Reset mid-divide discards all partial state.
- Single-cycle op: latency 1, throughput 1 per cycle.
- `valid_o`=0 on any cycle whose preceding edge retired nothing.
- MULT/MULTU: accept cycle + MUL + FIN.
  - `stallreq` is high for 2 cycles.
  - HI/LO are updated at the end of cycle 3.
  - `valid_o` pulses in cycle 4.
- DIV/DIVU: accept + XLEN DIV cycles + FIN.
  - `stallreq` is high for XLEN+1 cycles.
  - HI/LO are updated at the end of cycle XLEN+2.
  - `valid_o` pulses the following cycle.
- Divide by zero: accept + FIN, with `stallreq` high for 1 cycle.
- MFHI/MFLO issued in the cycle after a FIN read the newly written HI/LO.
- MTHI/MTLO followed immediately by MFHI/MFLO read the new value.

## Test plan
- Reset mid-DIV: drive reset in DIV cycle 10 → all outputs 0 immediately. After release, IDLE with `stallreq`=0 and HI/LO = 0.
- ADD 0x7FFFFFFF + 1 → `wdata_o`=0x80000000, `ov_o`=1, `wreg_o`=0. ADDU with the same operands → `wreg_o`=`wreg_i`, `ov_o`=0. SLT 0xFFFFFFFF,1 → 1. SLTU with the same operands → 0. SRA 0x80000000 by 4 → 0xF8000000.
- MULT 0xFFFFFFFE × 3 → `stallreq` high 2 cycles, {HI,LO} = 0xFFFFFFFF_FFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA. `valid_o` pulses exactly once, in cycle 4.
- DIV −7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, `stallreq` high 33 cycles (XLEN=32). DIVU 7 ÷ 0 → LO=0xFFFFFFFF, HI=7, `stallreq` high 1 cycle. DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- `flush_i` in DIV cycle 5 → IDLE next cycle, HI/LO unchanged, no `valid_o` pulse. A following ADD completes with latency 1.
- MTLO 0x1234 then MFLO back-to-back → second result 0x1234. Re-run with XLEN=16: DIVU 100 ÷ 7 → LO=14, HI=2, `stallreq` high 17 cycles.
